id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core. It sits directly downstream of the hazard control-zeroing mux. It captures the (possibly zeroed) decode control bits and the decode-stage operands every cycle and presents them to the EX stage, the forwarding unit and the hazard detection unit. It adds hold (stall), flush (bubble) and a valid flag, plus a saturating bubble counter for performance debug.

## Interface
- `BUBCNT_W`, default 16: width of the bubble counter.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `stall_i` input 1: hold all state this cycle.
- `flush_i` input 1: load a bubble this cycle.
- `bubble_i` input 1: the hazard signal driving the upstream zeroing mux; used only for counting.
- `RegDst_i`, `ALUSrc_i`, `MemtoReg_i`, `RegWrite_i`, `MemWrite_i`, `ExtOp_i`, `MemRead_i` input 1 each: decode control bits.
- `ALUOp_i` input 2: ALU op class.
- `pc4_i` input 32: PC+4 of the instruction.
- `rs_data_i`, `rt_data_i` input 32 each: register file read data.
- `imm_i` input 32: extended immediate.
- `rs_addr_i`, `rt_addr_i`, `rd_addr_i` input 5 each: register specifiers.
- `*_o` outputs: registered copies of every `*_i` above, with the same widths.
- `valid_o` output 1: the EX stage holds a real instruction.
- `bubcnt_o` output `BUBCNT_W`: bubbles entered, saturating.

## Operation
Per-edge priority is reset > stall_i > flush_i > load.

- **Reset (rst_i=0, asynchronous):**
  - All outputs go to 0, including `valid_o` and `bubcnt_o`.
  - Outputs stay 0 while reset is asserted.
  - Reset asserted mid-operation discards the captured instruction immediately, without waiting for an edge.
- **Stall (stall_i=1):**
  - Every register holds, including `valid_o` and `bubcnt_o`.
  - flush_i and bubble_i are ignored.
- **Flush (stall_i=0, flush_i=1):**
  - All 8 control outputs and `valid_o` load 0.
  - Data and address fields load their inputs normally. They are don't-care but deterministic.
  - `bubcnt_o` increments.
- **Load (stall_i=0, flush_i=0):**
  - All fields load their inputs.
  - `valid_o` loads `~bubble_i`.
  - If bubble_i=1, `bubcnt_o` increments. The control inputs are already zero from the upstream mux and are loaded as given; this block does not re-zero them.
- **Bubble counter:**
  - Increments by 1 per bubble event.
  - Saturates at 2^BUBCNT_W−1 and never wraps.
  - flush_i=1 and bubble_i=1 in the same cycle count as one event.
- **Safety rule:** while `valid_o`=0, `RegWrite_o`, `MemWrite_o` and `MemRead_o` must be 0 whenever the value came from a flush. Load-path bubbles rely on the upstream zeroing.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are register-driven, with no combinational input-to-output paths.
- stall_i, flush_i and bubble_i are sampled on the same edge as the data.
- A stall held for k cycles keeps the outputs constant for k edges. Loading resumes on the first edge with stall_i=0.
- Reset deassertion is synchronous to the design's clock. The first load occurs on the first rising edge with rst_i=1.

## Test plan
- **Reset:** drive all inputs to 1 or all-ones, pulse rst_i=0 between edges → all outputs are 0 immediately. After release and one edge with no stall or flush, outputs equal the inputs and `valid_o`=1.
- **Load:** rs_data_i=0x12345678, imm_i=0xFFFFFFF0, RegWrite_i=1, ALUOp_i=2'b10, rd_addr_i=5'd9 → these values appear one edge later with `valid_o`=1 and `bubcnt_o`=0.
- **Stall:** load value A, then apply stall_i=1 for 3 edges while the inputs change to B with flush_i=1 → outputs stay at A, `valid_o`=1, `bubcnt_o` unchanged. Release the stall → the next edge loads B.
- **Flush:** all control inputs at 1 with flush_i=1 → every control output is 0, `valid_o`=0, data fields equal the inputs, `bubcnt_o` goes 0→1. Asserting flush_i and bubble_i together increments the counter by 1 only.
- **Upstream bubble:** bubble_i=1 with zeroed control inputs → `valid_o`=0 and `bubcnt_o`+1. With BUBCNT_W=4, 20 consecutive bubbles → `bubcnt_o`=4'hF and it stays at 4'hF.
- **Reset mid-stall:** load A, hold stall_i=1, assert rst_i=0 mid-cycle → outputs and `bubcnt_o` are 0 without waiting for an edge. They remain 0 until reset is released.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode controls and operands for the EX stage.
// Adds stall hold, flush bubble, a valid flag and a saturating bubble counter.
module id_ex_reg #(
    parameter int BUBCNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                bubble_i,
    input  logic                RegDst_i,
    input  logic                ALUSrc_i,
    input  logic                MemtoReg_i,
    input  logic                RegWrite_i,
    input  logic                MemWrite_i,
    input  logic                ExtOp_i,
    input  logic                MemRead_i,
    input  logic [1:0]          ALUOp_i,
    input  logic [31:0]         pc4_i,
    input  logic [31:0]         rs_data_i,
    input  logic [31:0]         rt_data_i,
    input  logic [31:0]         imm_i,
    input  logic [4:0]          rs_addr_i,
    input  logic [4:0]          rt_addr_i,
    input  logic [4:0]          rd_addr_i,
    output logic                RegDst_o,
    output logic                ALUSrc_o,
    output logic                MemtoReg_o,
    output logic                RegWrite_o,
    output logic                MemWrite_o,
    output logic                ExtOp_o,
    output logic                MemRead_o,
    output logic [1:0]          ALUOp_o,
    output logic [31:0]         pc4_o,
    output logic [31:0]         rs_data_o,
    output logic [31:0]         rt_data_o,
    output logic [31:0]         imm_o,
    output logic [4:0]          rs_addr_o,
    output logic [4:0]          rt_addr_o,
    output logic [4:0]          rd_addr_o,
    output logic                valid_o,
    output logic [BUBCNT_W-1:0] bubcnt_o
);

    logic bubble_event;
    assign bubble_event = flush_i | bubble_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            ExtOp_o    <= 1'b0;
            MemRead_o  <= 1'b0;
            ALUOp_o    <= 2'b00;
            pc4_o      <= 32'h0;
            rs_data_o  <= 32'h0;
            rt_data_o  <= 32'h0;
            imm_o      <= 32'h0;
            rs_addr_o  <= 5'd0;
            rt_addr_o  <= 5'd0;
            rd_addr_o  <= 5'd0;
            valid_o    <= 1'b0;
            bubcnt_o   <= '0;
        end else if (!stall_i) begin
            // Operand fields load on flush too; they are ignored while valid_o is low.
            pc4_o     <= pc4_i;
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_addr_o <= rs_addr_i;
            rt_addr_o <= rt_addr_i;
            rd_addr_o <= rd_addr_i;
            if (flush_i) begin
                RegDst_o   <= 1'b0;
                ALUSrc_o   <= 1'b0;
                MemtoReg_o <= 1'b0;
                RegWrite_o <= 1'b0;
                MemWrite_o <= 1'b0;
                ExtOp_o    <= 1'b0;
                MemRead_o  <= 1'b0;
                ALUOp_o    <= 2'b00;
                valid_o    <= 1'b0;
            end else begin
                RegDst_o   <= RegDst_i;
                ALUSrc_o   <= ALUSrc_i;
                MemtoReg_o <= MemtoReg_i;
                RegWrite_o <= RegWrite_i;
                MemWrite_o <= MemWrite_i;
                ExtOp_o    <= ExtOp_i;
                MemRead_o  <= MemRead_i;
                ALUOp_o    <= ALUOp_i;
                valid_o    <= ~bubble_i;
            end
            if (bubble_event && (bubcnt_o != {BUBCNT_W{1'b1}}))
                bubcnt_o <= bubcnt_o + {{(BUBCNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed plan steps plus random traffic against a rule-level model.
module tb_id_ex_reg;
    localparam int W = 4;
    localparam int CNT_MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, flush = 1'b0, bubble = 1'b0;
    logic [8:0]  ctrl_in = '0;  // {RegDst,ALUSrc,MemtoReg,RegWrite,MemWrite,ExtOp,MemRead,ALUOp[1:0]}
    logic [31:0] pc4_in = '0, rs_in = '0, rt_in = '0, imm_in = '0;
    logic [4:0]  rsa_in = '0, rta_in = '0, rda_in = '0;

    logic        RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, ExtOp_o, MemRead_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] pc4_o, rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic        valid_o;
    logic [W-1:0] bubcnt_o;

    int tests = 0, fails = 0;

    logic [8:0]  e_ctrl;
    logic [31:0] e_pc4, e_rs, e_rt, e_imm;
    logic [4:0]  e_rsa, e_rta, e_rda;
    logic        e_valid;
    int          e_cnt;

    id_ex_reg #(.BUBCNT_W(W)) dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .bubble_i(bubble),
        .RegDst_i(ctrl_in[8]), .ALUSrc_i(ctrl_in[7]), .MemtoReg_i(ctrl_in[6]),
        .RegWrite_i(ctrl_in[5]), .MemWrite_i(ctrl_in[4]), .ExtOp_i(ctrl_in[3]),
        .MemRead_i(ctrl_in[2]), .ALUOp_i(ctrl_in[1:0]),
        .pc4_i(pc4_in), .rs_data_i(rs_in), .rt_data_i(rt_in), .imm_i(imm_in),
        .rs_addr_i(rsa_in), .rt_addr_i(rta_in), .rd_addr_i(rda_in),
        .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .MemtoReg_o(MemtoReg_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .ExtOp_o(ExtOp_o),
        .MemRead_o(MemRead_o), .ALUOp_o(ALUOp_o),
        .pc4_o(pc4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
        .valid_o(valid_o), .bubcnt_o(bubcnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_ctrl = '0; e_pc4 = '0; e_rs = '0; e_rt = '0; e_imm = '0;
        e_rsa = '0; e_rta = '0; e_rda = '0; e_valid = 1'b0; e_cnt = 0;
    endtask

    // Rule-level model of one rising edge.
    task automatic model_edge();
        if (!rst_n) model_reset();
        else if (!stall) begin
            e_pc4 = pc4_in; e_rs = rs_in; e_rt = rt_in; e_imm = imm_in;
            e_rsa = rsa_in; e_rta = rta_in; e_rda = rda_in;
            e_ctrl  = flush ? 9'd0 : ctrl_in;
            e_valid = !(flush || bubble);
            if ((flush || bubble) && e_cnt < CNT_MAX) e_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ctrl"}, 32'({RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o,
                                  ExtOp_o, MemRead_o, ALUOp_o}), 32'(e_ctrl));
        check({tag, ".pc4"}, pc4_o, e_pc4);
        check({tag, ".rs"}, rs_data_o, e_rs);
        check({tag, ".rt"}, rt_data_o, e_rt);
        check({tag, ".imm"}, imm_o, e_imm);
        check({tag, ".addr"}, 32'({rs_addr_o, rt_addr_o, rd_addr_o}), 32'({e_rsa, e_rta, e_rda}));
        check({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
        check({tag, ".bubcnt"}, 32'(bubcnt_o), 32'(e_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_data();
        pc4_in = $urandom; rs_in = $urandom; rt_in = $urandom; imm_in = $urandom;
        rsa_in = 5'($urandom); rta_in = 5'($urandom); rda_in = 5'($urandom);
    endtask

    task automatic set_ones();
        ctrl_in = '1; pc4_in = '1; rs_in = '1; rt_in = '1; imm_in = '1;
        rsa_in = '1; rta_in = '1; rda_in = '1;
    endtask

    initial begin
        // Reset with every input high
        set_ones(); stall = 1'b1; flush = 1'b1; bubble = 1'b1;
        model_reset();
        #3; check_all("rst_hold");
        @(posedge clk); #1; check_all("rst_edge");
        stall = 1'b0; flush = 1'b0; bubble = 1'b0;
        #2 rst_n = 1'b1;
        step("rst_release");

        // Directed load
        rand_data(); ctrl_in = 9'b000100010; rs_in = 32'h12345678; imm_in = 32'hFFFFFFF0; rda_in = 5'd9;
        step("load");
        check("load.rs_const", rs_data_o, 32'h12345678);
        check("load.valid_const", 32'(valid_o), 32'd1);

        // Stall holds A while inputs change to B with flush asserted
        stall = 1'b1; flush = 1'b1; rand_data(); ctrl_in = 9'h1AB;
        for (int i = 0; i < 3; i++) step("stall");
        stall = 1'b0; flush = 1'b0;
        step("stall_release");

        // Flush with all controls high, then flush together with bubble
        ctrl_in = '1; flush = 1'b1; rand_data();
        step("flush");
        bubble = 1'b1; rand_data();
        step("flush_bubble");
        flush = 1'b0; bubble = 1'b0;

        // Upstream bubbles to saturation
        for (int i = 0; i < 20; i++) begin
            bubble = 1'b1; ctrl_in = '0; rand_data();
            step("bubble_sat");
        end
        check("bubble_sat.max", 32'(bubcnt_o), 32'hF);
        bubble = 1'b0;

        // Reset mid-stall
        ctrl_in = 9'h155; rand_data();
        step("pre_mid_reset");
        stall = 1'b1;
        step("mid_stall");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("mid_reset");
        step("mid_reset_edge");
        #2 rst_n = 1'b1;
        stall = 1'b0;
        step("after_mid_reset");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            stall  = ($urandom_range(3) == 0);
            flush  = ($urandom_range(4) == 0);
            bubble = ($urandom_range(3) == 0);
            ctrl_in = bubble ? 9'd0 : 9'($urandom);
            rand_data();
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
